wb_port_arbiter: RTL

- Shares the register file's single write port between the two writeback lanes of the dual-issue pipe.
- Lane 0 is always the older instruction in program order; lane 1 is the younger.
- Writeback results are buffered in an in-order queue and retired to the register file at one write per cycle.
- Drops same-cycle same-destination (WAW) results from the older lane, and exposes a pending-write lookup for hazard and bypass logic.

---
 rtl/wb_pkg.sv | 16 +
 rtl/wb_lane_mux.sv | 24 ++
 rtl/wb_port_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared widths, instruction field positions and the queued writeback entry
// type for the register-file write-port arbiter.
package wb_pkg;

    localparam int DATA_W   = 16;
    localparam int AW       = 3;
    localparam int INSTR_W  = 16;
    localparam int DEST_MSB = 10;
    localparam int DEST_LSB = 8;

    typedef struct packed {
        logic [AW-1:0]     dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_lane_mux.sv
// Per-lane writeback formation: picks load or ALU result and extracts the
// destination register from the instruction word.
module wb_lane_mux
    import wb_pkg::*;
(
    input  logic               isld,
    input  logic [INSTR_W-1:0] instr,
    input  logic [DATA_W-1:0]  ldresult,
    input  logic [DATA_W-1:0]  aluresult,
    output wb_entry_t          entry
);

    // Result source select and destination field extraction
    always_comb begin
        entry      = '0;
        entry.dest = instr[DEST_MSB:DEST_LSB];
        if (isld) begin
            entry.data = ldresult;
        end else begin
            entry.data = aluresult;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Funnels two writeback lanes into the single register-file write port via an
// in-order queue, dropping same-cycle WAW older results and exposing a lookup.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in0_valid,
    input  logic                     in0_isld,
    input  logic [INSTR_W-1:0]       in0_instr,
    input  logic [DATA_W-1:0]        in0_ldresult,
    input  logic [DATA_W-1:0]        in0_aluresult,
    input  logic                     in1_valid,
    input  logic                     in1_isld,
    input  logic [INSTR_W-1:0]       in1_instr,
    input  logic [DATA_W-1:0]        in1_ldresult,
    input  logic [DATA_W-1:0]        in1_aluresult,
    output logic                     in_ready,
    output logic                     rf_we,
    output logic [AW-1:0]            rf_waddr,
    output logic [DATA_W-1:0]        rf_wdata,
    output logic [$clog2(DEPTH):0]   occupancy,
    input  logic [AW-1:0]            query_addr,
    output logic                     query_hit,
    output logic [DATA_W-1:0]        query_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t        lane0_s;
    wb_entry_t        lane1_s;
    wb_entry_t        mem_r [DEPTH];
    logic [PW-1:0]    head_r;
    logic [PW-1:0]    tail_r;
    logic [CW-1:0]    count_r;

    logic             in_ready_s;
    logic             coalesce_s;
    logic             wr0_s;
    logic             wr1_s;
    logic             deq_s;
    logic [1:0]       n_enq_s;
    logic [PW-1:0]    slot1_s;
    logic             query_hit_s;
    logic [DATA_W-1:0] query_data_s;

    wb_lane_mux u_lane0 (
        .isld      (in0_isld),
        .instr     (in0_instr),
        .ldresult  (in0_ldresult),
        .aluresult (in0_aluresult),
        .entry     (lane0_s)
    );

    wb_lane_mux u_lane1 (
        .isld      (in1_isld),
        .instr     (in1_instr),
        .ldresult  (in1_ldresult),
        .aluresult (in1_aluresult),
        .entry     (lane1_s)
    );

    // Accept/coalesce decision and slot assignment for this cycle's lanes
    always_comb begin
        in_ready_s = (count_r <= CW'(DEPTH - 2));
        coalesce_s = in0_valid && in1_valid && (lane0_s.dest == lane1_s.dest);
        wr0_s      = in_ready_s && in0_valid && !coalesce_s;
        wr1_s      = in_ready_s && in1_valid;
        deq_s      = (count_r != '0);
        n_enq_s    = {1'b0, wr0_s} + {1'b0, wr1_s};
        if (wr0_s) begin
            slot1_s = tail_r + PW'(1'b1);
        end else begin
            slot1_s = tail_r;
        end
    end

    // Pointer and count state; reset discards everything queued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            if (deq_s) begin
                head_r <= head_r + PW'(1'b1);
            end
            tail_r  <= tail_r + PW'(n_enq_s);
            count_r <= count_r + CW'(n_enq_s) - CW'(deq_s);
        end
    end

    // Queue storage writes; lane 0 is older so it takes the lower slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (wr0_s) begin
                mem_r[tail_r] <= lane0_s;
            end
            if (wr1_s) begin
                mem_r[slot1_s] <= lane1_s;
            end
        end
    end

    // Pending-write lookup; walking oldest to youngest lets the youngest match win
    always_comb begin
        logic [PW-1:0] idx_v;
        query_hit_s  = 1'b0;
        query_data_s = '0;
        idx_v        = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx_v = head_r + PW'(k);
            if ((CW'(k) < count_r) && (mem_r[idx_v].dest == query_addr)) begin
                query_hit_s  = 1'b1;
                query_data_s = mem_r[idx_v].data;
            end else begin
                query_hit_s  = query_hit_s;
                query_data_s = query_data_s;
            end
        end
    end

    assign in_ready   = in_ready_s;
    assign rf_we      = deq_s;
    assign rf_waddr   = mem_r[head_r].dest;
    assign rf_wdata   = mem_r[head_r].data;
    assign occupancy  = count_r;
    assign query_hit  = query_hit_s;
    assign query_data = query_data_s;

endmodule
